program_loader: RTL
===================

# program_loader

Boot-time program loader between an external byte-stream source and the shared 8-bit RAM port of the unicycle datapath. It holds the core in reset, writes a stream of bytes into consecutive RAM addresses starting at 0, then releases the core. After release it passes the core's memory signals through to the RAM unchanged. It also keeps an additive checksum of the loaded image for bench and host comparison.

## Interface
- DEPTH, 256: RAM words; LoadLen=0 means DEPTH bytes
- CLK  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high
- LoadStart  in  1  one-cycle request to begin a load session
- LoadLen  in  8  byte count for the session, sampled with LoadStart
- InValid  in  1  source has a byte on InData
- InData  in  8  byte from source
- InReady  out  1  loader accepts InData this cycle
- CoreAddr  in  8  core memory address (ALU result)
- CoreWData  in  8  core write data
- CoreWrite  in  1  core write enable
- CoreRead  in  1  core read enable
- MemAddr  out  8  RAM address
- MemData  out  8  RAM write data
- MemWrite  out  1  RAM write enable
- MemRead  out  1  RAM read enable
- CoreReset  out  1  reset to datapath, active-high
- Busy  out  1  load session in progress (LOAD or FLUSH)
- Done  out  1  sticky: last session completed
- Checksum  out  8  mod-256 sum of bytes accepted in the current/last session

## Operation
- States: HOLD, LOAD, FLUSH, RUN. Reset forces HOLD asynchronously.
- HOLD:
  - CoreReset=1; RAM port idle (MemWrite=0, MemRead=0).
  - LoadStart -> LOAD.
- LOAD:
  - CoreReset=1; InReady=1 while Count < Len.
  - Accept when InValid & InReady. On accept:
    - register MemAddr=Count, MemData=InData, MemWrite=1 for the next cycle;
    - Count+1; Checksum += InData (wraps mod 256).
  - Cycles without an accept drive MemWrite=0.
  - Accept of the last byte (Count becomes Len) -> FLUSH; InReady drops in the same edge.
- FLUSH:
  - Exactly one cycle; the last registered write is presented to the RAM.
  - InReady=0; then -> RUN.
- RUN:
  - CoreReset=0.
  - Mem outputs equal the Core inputs combinationally: MemAddr=CoreAddr, MemData=CoreWData, MemWrite=CoreWrite, MemRead=CoreRead.
  - LoadStart -> LOAD, with CoreReset=1 from the next edge.
- Session start, from HOLD or RUN:
  - Len = (LoadLen==0) ? DEPTH : LoadLen (9-bit internal).
  - Count=0, Checksum=0, Done=0.
- Done is set on the FLUSH->RUN edge and holds until the next session start or Reset.
- LoadStart in LOAD or FLUSH is ignored; Len, Count and Checksum are unchanged.
- Core inputs are ignored outside RUN.
- Count never exceeds Len; the address wraps only at DEPTH, which equals Len's maximum.
- Reset mid-load:
  - -> HOLD, Done=0, Count=0, Checksum=0.
  - RAM bytes already written are kept; the loader does not clear RAM.

## Timing
- Reset values:
  - CoreReset=1, InReady=0, Busy=0, Done=0, Checksum=0.
  - MemAddr=0, MemData=0, MemWrite=0, MemRead=0.
- LoadStart at edge k: InReady=1 from cycle k+1.
- Byte accepted at edge j: MemWrite=1 during cycle j+1; RAM captures at edge j+2.
- Throughput: one byte per cycle while InValid stays high.
- N-byte back-to-back load after LoadStart at edge k:
  - last accept at edge k+N;
  - FLUSH during cycle k+N+1;
  - CoreReset=0 and Done=1 from edge k+N+2.
- Busy=1 exactly in LOAD and FLUSH.
- InReady depends only on state and Count, never on InValid.

## Test plan
- Reset mid-stream: Reset pulse -> all outputs at reset values; LoadStart, LoadLen=4, bytes 0x11,0x22,0x33,0x44 back-to-back -> RAM[0..3] hold those bytes, Checksum=0xAA, Done=1 and CoreReset=0 exactly 6 edges after LoadStart.
- Stalled source: LoadLen=3, InValid toggled 1,0,0,1,0,1 with 0x05,0x06,0x07 -> MemWrite high only the cycle after each accept, RAM[0..2]=05,06,07, Checksum=0x12.
- Full image: LoadLen=0, 256 bytes of value i -> RAM[i]=i for all i, Count stops at 256, Checksum=0x80, InReady=0 after the 256th accept.
- Pass-through and reload: in RUN drive CoreAddr=0x10, CoreWData=0x5A, CoreWrite=1 -> RAM[0x10]=0x5A; then LoadStart, LoadLen=1 -> CoreReset=1, Done=0, Core inputs ignored, RAM[0]=new byte.
- Ignored start and abort: LoadStart pulsed mid-LOAD -> Len, Count and Checksum unchanged; Reset asserted after 2 of 4 bytes -> state HOLD, Done=0, CoreReset=1, RAM[0..1] written and RAM[2..3] untouched.

Source files
------------

// File: rtl/program_loader_if.sv
// Loader-side bus bundle: byte-stream source, core memory port, RAM port and status.
// State is a debug copy of the loader FSM: 0=HOLD, 1=LOAD, 2=FLUSH, 3=RUN.
// Handshake: a byte moves on a rising edge where InValid and InReady are both high;
// InReady depends only on loader state and count, and InData is don't-care otherwise.
interface program_loader_if;
    logic       LoadStart;
    logic [7:0] LoadLen;
    logic       InValid;
    logic [7:0] InData;
    logic       InReady;
    logic [7:0] CoreAddr;
    logic [7:0] CoreWData;
    logic       CoreWrite;
    logic       CoreRead;
    logic [7:0] MemAddr;
    logic [7:0] MemData;
    logic       MemWrite;
    logic       MemRead;
    logic       CoreReset;
    logic       Busy;
    logic       Done;
    logic [7:0] Checksum;
    logic [1:0] State;

    modport master (
        output LoadStart, LoadLen, InValid, InData, CoreAddr, CoreWData, CoreWrite, CoreRead,
        input  InReady, MemAddr, MemData, MemWrite, MemRead, CoreReset, Busy, Done, Checksum, State
    );

    modport slave (
        input  LoadStart, LoadLen, InValid, InData, CoreAddr, CoreWData, CoreWrite, CoreRead,
        output InReady, MemAddr, MemData, MemWrite, MemRead, CoreReset, Busy, Done, Checksum, State
    );
endinterface

// File: rtl/program_loader.sv
// Boot-time program loader: holds the core in reset, streams bytes into RAM from
// address 0, then hands the RAM port to the core as a combinational pass-through.
module program_loader #(
    parameter int DEPTH = 256
) (
    input logic             CLK,
    input logic             Reset,
    program_loader_if.slave bus
);
    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam logic [8:0] LEN_FULL = 9'(DEPTH);

    state_t     state;
    logic [8:0] len;
    logic [8:0] count;
    logic [7:0] checksum;
    logic       done;

    // Accepted byte is captured first, then presented to the RAM one cycle later,
    // which puts the final byte on the RAM port during FLUSH.
    logic       cap_we;
    logic [7:0] cap_addr;
    logic [7:0] cap_data;
    logic       out_we;
    logic [7:0] out_addr;
    logic [7:0] out_data;

    logic       run;
    logic       in_ready;
    logic       accept;

    assign run      = (state == RUN);
    assign in_ready = (state == LOAD) && (count < len);
    assign accept   = in_ready && bus.InValid;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state    <= HOLD;
            len      <= '0;
            count    <= '0;
            checksum <= '0;
            done     <= 1'b0;
            cap_we   <= 1'b0;
            cap_addr <= '0;
            cap_data <= '0;
            out_we   <= 1'b0;
            out_addr <= '0;
            out_data <= '0;
        end else begin
            out_we   <= cap_we;
            out_addr <= cap_addr;
            out_data <= cap_data;
            cap_we   <= 1'b0;
            case (state)
                HOLD, RUN: begin
                    if (bus.LoadStart) begin
                        state    <= LOAD;
                        len      <= (bus.LoadLen == 8'd0) ? LEN_FULL : {1'b0, bus.LoadLen};
                        count    <= '0;
                        checksum <= '0;
                        done     <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        cap_we   <= 1'b1;
                        cap_addr <= count[7:0];
                        cap_data <= bus.InData;
                        count    <= count + 9'd1;
                        checksum <= checksum + bus.InData;
                    end else if (count == len) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    state <= RUN;
                    done  <= 1'b1;
                end
                default: state <= HOLD;
            endcase
        end
    end

    assign bus.InReady   = in_ready;
    assign bus.MemAddr   = run ? bus.CoreAddr  : out_addr;
    assign bus.MemData   = run ? bus.CoreWData : out_data;
    assign bus.MemWrite  = run ? bus.CoreWrite : out_we;
    assign bus.MemRead   = run ? bus.CoreRead  : 1'b0;
    assign bus.CoreReset = !run;
    assign bus.Busy      = (state == LOAD) || (state == FLUSH);
    assign bus.Done      = done;
    assign bus.Checksum  = checksum;
    assign bus.State     = state;
endmodule
